reg_mux: RTL and testbench

- Parameterised N-to-1 data selector with a registered output, one cycle of latency.
- Selects one of 2**SELECT_SIZE input words of DATA_SIZE bits using the binary select `port`, and registers the result on the rising clock edge.
- General-purpose datapath primitive for steering buses between producers and a single consumer in the clocked fabric.

---
 rtl/reg_mux.sv | 45 ++++
 tb/tb_reg_mux.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_mux.sv
// Parameterised N-to-1 selector with a registered output and a registered copy
// of the select value. Latency is one clock from an edge to out/out_port.
module reg_mux #(
  parameter int                   DATA_SIZE   = 4,
  parameter int                   SELECT_SIZE = 2,
  parameter logic [DATA_SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [SELECT_SIZE-1:0] port,
  input  logic [DATA_SIZE-1:0]   in [2**SELECT_SIZE-1:0],
  output logic [DATA_SIZE-1:0]   out,
  output logic [SELECT_SIZE-1:0] out_port
);

  localparam int NUM_IN = 2**SELECT_SIZE;

  logic [DATA_SIZE-1:0]   sel_p0;
  logic [DATA_SIZE-1:0]   out_p1;
  logic [SELECT_SIZE-1:0] port_p1;

  // Stage p0: select the addressed word; every encoding of port maps to an input
  always_comb begin
    sel_p0 = in[0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (port == SELECT_SIZE'(k)) sel_p0 = in[k];
    end
  end

  // Stage p1: capture on enable, asynchronous clear to the reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1  <= RESET_VALUE;
      port_p1 <= '0;
    end else if (en) begin
      out_p1  <= sel_p0;
      port_p1 <= port;
    end
  end

  assign out      = out_p1;
  assign out_port = port_p1;

endmodule

// File: tb/tb_reg_mux.sv
// Directed bench for reg_mux: default 4-bit/4-input instance plus an
// 8-bit/8-input instance for the parameterised case.
module tb_reg_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] port;
  logic [3:0] in [3:0];
  logic [3:0] out;
  logic [1:0] out_port;

  logic       en8;
  logic [2:0] port8;
  logic [7:0] in8 [7:0];
  logic [7:0] out8;
  logic [2:0] out_port8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_mux dut (
    .clk(clk), .rst_n(rst_n), .en(en), .port(port), .in(in),
    .out(out), .out_port(out_port)
  );

  reg_mux #(.DATA_SIZE(8), .SELECT_SIZE(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .port(port8), .in(in8),
    .out(out8), .out_port(out_port8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    port  = 2'd3;
    tick();
    tick();
    checks++;
    if (out !== 4'h0) begin
      errors++; $display("FAIL reset_out got %h want %h", out, 4'h0);
    end
    checks++;
    if (out_port !== 2'd0) begin
      errors++; $display("FAIL reset_port got %0d want %0d", out_port, 0);
    end
    checks++;
    if (out8 !== 8'h00) begin
      errors++; $display("FAIL reset_out8 got %h want %h", out8, 8'h00);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [3:0] exp_v [4];
    exp_v = '{4'hE, 4'hC, 4'hA, 4'hF};
    en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      port = 2'(p);
      tick();
      checks++;
      if (out !== exp_v[p]) begin
        errors++; $display("FAIL sweep_out[%0d] got %h want %h", p, out, exp_v[p]);
      end
      checks++;
      if (out_port !== 2'(p)) begin
        errors++; $display("FAIL sweep_port[%0d] got %0d want %0d", p, out_port, p);
      end
    end
  endtask

  task automatic test_hold();
    en   = 1'b1;
    port = 2'd2;
    tick();
    checks++;
    if (out !== 4'hA) begin
      errors++; $display("FAIL hold_capture got %h want %h", out, 4'hA);
    end
    en   = 1'b0;
    port = 2'd3;
    for (int i = 0; i < 3; i++) begin
      in[2] = 4'(i);
      tick();
      checks++;
      if (out !== 4'hA) begin
        errors++; $display("FAIL hold_out[%0d] got %h want %h", i, out, 4'hA);
      end
      checks++;
      if (out_port !== 2'd2) begin
        errors++; $display("FAIL hold_port[%0d] got %0d want %0d", i, out_port, 2);
      end
    end
    in[2] = 4'hA;
    en    = 1'b1;
    tick();
    checks++;
    if (out !== 4'hF) begin
      errors++; $display("FAIL hold_reenable got %h want %h", out, 4'hF);
    end
    checks++;
    if (out_port !== 2'd3) begin
      errors++; $display("FAIL hold_reenable_port got %0d want %0d", out_port, 3);
    end
  endtask

  task automatic test_tracking();
    en   = 1'b1;
    port = 2'd1;
    tick();
    checks++;
    if (out !== 4'hC) begin
      errors++; $display("FAIL track_first got %h want %h", out, 4'hC);
    end
    in[1] = 4'h5;
    tick();
    checks++;
    if (out !== 4'h5) begin
      errors++; $display("FAIL track_new got %h want %h", out, 4'h5);
    end
    // Mid-cycle glitch on the selected input must not reach out before the edge
    in[1] = 4'h9;
    #2;
    checks++;
    if (out !== 4'h5) begin
      errors++; $display("FAIL track_no_comb got %h want %h", out, 4'h5);
    end
    in[1] = 4'hC;
  endtask

  task automatic test_async_reset();
    en   = 1'b1;
    port = 2'd3;
    tick();
    checks++;
    if (out !== 4'hF) begin
      errors++; $display("FAIL async_pre got %h want %h", out, 4'hF);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 4'h0) begin
      errors++; $display("FAIL async_immediate got %h want %h", out, 4'h0);
    end
    checks++;
    if (out_port !== 2'd0) begin
      errors++; $display("FAIL async_port got %0d want %0d", out_port, 0);
    end
    #1;
    rst_n = 1'b1;
    port  = 2'd0;
    tick();
    checks++;
    if (out !== 4'hE) begin
      errors++; $display("FAIL async_resume got %h want %h", out, 4'hE);
    end
  endtask

  task automatic test_param();
    en    = 1'b0;
    en8   = 1'b1;
    port8 = 3'd7;
    tick();
    checks++;
    if (out8 !== 8'h17) begin
      errors++; $display("FAIL param_p7 got %h want %h", out8, 8'h17);
    end
    checks++;
    if (out_port8 !== 3'd7) begin
      errors++; $display("FAIL param_port7 got %0d want %0d", out_port8, 7);
    end
    port8 = 3'd0;
    tick();
    checks++;
    if (out8 !== 8'h10) begin
      errors++; $display("FAIL param_p0 got %h want %h", out8, 8'h10);
    end
    port8 = 3'd5;
    tick();
    checks++;
    if (out8 !== 8'h15) begin
      errors++; $display("FAIL param_p5 got %h want %h", out8, 8'h15);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    port  = '0;
    in[0] = 4'hE; in[1] = 4'hC; in[2] = 4'hA; in[3] = 4'hF;
    en8   = 1'b0;
    port8 = '0;
    for (int k = 0; k < 8; k++) in8[k] = 8'h10 + 8'(k);

    test_reset();
    test_sweep();
    test_hold();
    test_tracking();
    test_async_reset();
    test_param();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
